input_mem_reader: RTL and testbench



---
 rtl/input_mem_reader.sv | 124 ++++++++++++
 tb/tb_input_mem_reader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/input_mem_reader.sv
// input_mem_reader: walks a programmable address window of an
// asynchronous-read word ROM, registers each word and offers it
// downstream on a valid/ready stream, then pulses done once.
module input_mem_reader #(
    parameter int num_of_words  = 16,
    parameter int bits_of_words = 16,
    parameter int address_bits  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [address_bits-1:0]  base,
    input  logic [address_bits:0]    len,
    output logic [address_bits-1:0]  mem_addr,
    input  logic [bits_of_words-1:0] mem_word,
    output logic [bits_of_words-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    // count register is one bit wider than the address so it can hold
    // the full memory depth
    localparam logic [address_bits:0]   DEPTH     = (address_bits+1)'(num_of_words);
    localparam logic [address_bits:0]   CNT_ONE   = (address_bits+1)'(1);
    localparam logic [address_bits-1:0] ADDR_ONE  = address_bits'(1);
    localparam logic [address_bits-1:0] LAST_ADDR = address_bits'(num_of_words - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    // a command after sanitising: start address and number of words
    typedef struct packed {
        logic [address_bits-1:0] addr;
        logic [address_bits:0]   count;
    } cmd_t;

    state_t                  state;
    logic [address_bits:0]   remaining;
    cmd_t                    cmd;
    logic [address_bits-1:0] next_addr;
    logic                    last_word;
    logic                    handshake;

    // clamp the incoming command to the memory and compute the next
    // address, wrapping at the real depth rather than at 2**address_bits
    always_comb begin
        cmd.count = (len > DEPTH) ? DEPTH : len;
        cmd.addr  = ({1'b0, base} >= DEPTH) ? '0 : base;
        next_addr = (mem_addr == LAST_ADDR) ? '0 : (mem_addr + ADDR_ONE);
        last_word = (remaining == CNT_ONE);
        handshake = out_valid & out_ready;
    end

    // sequencing FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            mem_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        remaining <= cmd.count;
                        mem_addr  <= cmd.addr;
                        if (cmd.count == '0) begin
                            // empty command: straight to the done pulse
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= READ;
                            busy  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    // mem_addr settled last cycle, so the ROM output is valid now
                    out_data  <= mem_word;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    // hold data/valid/addr until downstream takes the word
                    if (handshake) begin
                        remaining <= remaining - CNT_ONE;
                        out_valid <= 1'b0;
                        if (last_word) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            mem_addr <= next_addr;
                            state    <= READ;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_mem_reader.sv
// tb_input_mem_reader: table-driven directed commands, a reset-abort
// sequence and randomized commands checked against a window model.
module tb_input_mem_reader;

    localparam int NW = 16;
    localparam int BW = 16;
    localparam int AB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AB-1:0] base;
    logic [AB:0]   len;
    logic [AB-1:0] mem_addr;
    logic [BW-1:0] mem_word;
    logic [BW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    logic [BW-1:0] rom [NW];

    int total = 0;
    int bad   = 0;

    assign mem_word = rom[mem_addr];

    always #5 clk = ~clk;

    input_mem_reader #(
        .num_of_words (NW),
        .bits_of_words(BW),
        .address_bits (AB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base),
        .len      (len),
        .mem_addr (mem_addr),
        .mem_word (mem_word),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // reference: the words a command must deliver, in order
    function automatic int model_count(input int l);
        return (l > NW) ? NW : l;
    endfunction

    // mode 0: always ready, 1: random ready, 2: stall 5 cycles on word 2
    task automatic run_cmd(input int b, input int l, input int mode, input bit inject,
                           output int first, output int last);
        int n, edges, acc, stall, held, first_v;
        bit rdy, stalled;
        int got[$];
        n = model_count(l);
        got.delete();
        first = -1;
        last  = -1;
        @(negedge clk);
        start = 1'b1; base = AB'(b); len = (AB+1)'(l); out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            check("len0_done", done, 1);
            check("len0_busy", busy, 0);
        end else begin
            check("start_busy", busy, 1);
            check("start_addr", mem_addr, b % NW);
        end
        edges = 1; acc = 0; stall = 0; stalled = 0; held = 0; first_v = -1;
        while (!done) begin
            if (edges > 200) begin
                timeout("cmd_loop");
                break;
            end
            start = inject && (edges == 3);
            if (start) begin base = 4'd8; len = 5'd5; end
            rdy = 1'b1;
            if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            if (mode == 2 && acc == 1 && stall < 5) begin rdy = 1'b0; stall++; end
            if (out_valid) begin
                if (first_v < 0) first_v = edges;
                if (stalled) check("stall_data", out_data, held);
                check("addr_seq", mem_addr, (b + acc) % NW);
                if (rdy) begin got.push_back(int'(out_data)); acc++; end
                stalled = !rdy;
                held = int'(out_data);
            end else begin
                if (stalled) check("stall_valid", out_valid, 1);
                stalled = 1'b0;
            end
            out_ready = rdy;
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        check("done_busy", busy, 0);
        check("word_count", got.size(), n);
        for (int k = 0; k < got.size() && k < n; k++)
            check("word", got[k], int'(rom[(b + k) % NW]));
        if (n > 0) check("first_latency", first_v, 2);
        if (mode == 0 && !inject) check("cycles", edges, 2 * n + 1);
        if (got.size() > 0) begin first = got[0]; last = got[got.size()-1]; end
        // start during the DONE cycle must be ignored
        start = 1'b1; base = 4'd8; len = 5'd3;
        @(negedge clk);
        start = 1'b0;
        check("done_pulse_end", done, 0);
        check("done_start_ign", busy, 0);
        @(negedge clk);
        check("idle_after", busy | out_valid, 0);
    endtask

    typedef struct {
        int b;
        int l;
        int mode;
        bit inject;
        int first;
        int last;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int f, la, acc;
        rst = 1'b1; start = 1'b0; base = '0; len = '0; out_ready = 1'b0;
        for (int i = 0; i < NW; i++) rom[i] = BW'(16'h100 + i);

        vecs[0] = '{3, 4, 0, 0, 'h103, 'h106};
        vecs[1] = '{14, 5, 0, 0, 'h10E, 'h102};
        vecs[2] = '{0, 3, 2, 0, 'h100, 'h102};
        vecs[3] = '{0, 0, 0, 0, -1, -1};
        vecs[4] = '{7, 20, 0, 0, 'h107, 'h106};
        vecs[5] = '{15, 1, 0, 0, 'h10F, 'h10F};
        vecs[6] = '{4, 3, 0, 1, 'h104, 'h106};
        vecs[7] = '{9, 16, 1, 0, 'h109, 'h108};

        repeat (3) @(negedge clk);
        check("rst_addr", mem_addr, 0);
        check("rst_data", out_data, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].b, vecs[i].l, vecs[i].mode, vecs[i].inject, f, la);
            check("vec_first", f, vecs[i].first);
            check("vec_last", la, vecs[i].last);
        end

        // reset in SEND after two of six words
        @(negedge clk);
        start = 1'b1; base = 4'd0; len = 5'd6; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = 0;
        for (int c = 0; c < 60; c++) begin
            if (out_valid) begin
                if (acc == 2) break;
                acc++;
            end
            @(negedge clk);
        end
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1; start = 1'b1; base = 4'd9; len = 5'd2;
        @(negedge clk);
        check("abort_addr", mem_addr, 0);
        check("abort_data", out_data, 0);
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("abort_idle", busy | out_valid | done, 0);
        run_cmd(5, 2, 0, 0, f, la);
        check("post_rst_first", f, 'h105);
        check("post_rst_last", la, 'h106);

        // randomized commands over random ROM contents
        for (int i = 0; i < NW; i++) rom[i] = BW'($urandom);
        for (int t = 0; t < 25; t++)
            run_cmd(int'($urandom_range(0, NW-1)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), f, la);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
